// File: rtl/reorder_buffer_if.sv
// Interface between the reorder buffer and its surroundings: issue, CDB,
// operand lookup, commit and flush signals. Clock and reset stay outside.
interface reorder_buffer_if #(
    parameter int ROB_WIDTH_BIT = 3,
    parameter int REG_ID_BIT    = 5
);
    logic                     rdy_in;

    logic                     issue_en;
    logic [REG_ID_BIT-1:0]    issue_rd;
    logic                     issue_is_br;
    logic                     issue_pred;
    logic [31:0]              issue_pc;
    logic [ROB_WIDTH_BIT-1:0] tail_id;
    logic                     rob_full;

    logic                     cdb_en;
    logic [ROB_WIDTH_BIT-1:0] cdb_rob_id;
    logic [31:0]              cdb_value;
    logic                     cdb_taken;
    logic [31:0]              cdb_target;

    logic [ROB_WIDTH_BIT-1:0] q1_id;
    logic [ROB_WIDTH_BIT-1:0] q2_id;
    logic                     q1_ready;
    logic                     q2_ready;
    logic [31:0]              q1_value;
    logic [31:0]              q2_value;

    logic                     write_en;
    logic [REG_ID_BIT-1:0]    reg_id;
    logic [ROB_WIDTH_BIT-1:0] rob_id;
    logic [31:0]              value;
    logic                     flush_out;
    logic [31:0]              redirect_pc;

    // Driver side: decoder/issue, CDB and the testbench.
    modport master (
        output rdy_in, issue_en, issue_rd, issue_is_br, issue_pred, issue_pc,
        output cdb_en, cdb_rob_id, cdb_value, cdb_taken, cdb_target,
        output q1_id, q2_id,
        input  tail_id, rob_full, q1_ready, q2_ready, q1_value, q2_value,
        input  write_en, reg_id, rob_id, value, flush_out, redirect_pc
    );

    // Reorder buffer side.
    modport slave (
        input  rdy_in, issue_en, issue_rd, issue_is_br, issue_pred, issue_pc,
        input  cdb_en, cdb_rob_id, cdb_value, cdb_taken, cdb_target,
        input  q1_id, q2_id,
        output tail_id, rob_full, q1_ready, q2_ready, q1_value, q2_value,
        output write_en, reg_id, rob_id, value, flush_out, redirect_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer. Entries are allocated at the tail on
// issue, filled from the CDB, and retired from the head in program order.
// A mispredicted branch at the head flushes every entry.
module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = 3,
    parameter int REG_ID_BIT    = 5
) (
    input logic             clk_in,
    input logic             rst_n_in,
    reorder_buffer_if.slave rob_if
);
    localparam int DEPTH = 2 ** ROB_WIDTH_BIT;
    localparam int CW    = ROB_WIDTH_BIT + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef logic [ROB_WIDTH_BIT-1:0] id_t;

    logic                  busy_q   [DEPTH];
    logic                  busy_d   [DEPTH];
    logic                  ready_q  [DEPTH];
    logic                  ready_d  [DEPTH];
    logic [REG_ID_BIT-1:0] rd_q     [DEPTH];
    logic [REG_ID_BIT-1:0] rd_d     [DEPTH];
    logic                  is_br_q  [DEPTH];
    logic                  is_br_d  [DEPTH];
    logic                  pred_q   [DEPTH];
    logic                  pred_d   [DEPTH];
    logic [31:0]           pc_q     [DEPTH];
    logic [31:0]           pc_d     [DEPTH];
    logic [31:0]           ent_val_q[DEPTH];
    logic [31:0]           ent_val_d[DEPTH];
    logic                  taken_q  [DEPTH];
    logic                  taken_d  [DEPTH];
    logic [31:0]           target_q [DEPTH];
    logic [31:0]           target_d [DEPTH];

    id_t                   head_q, head_d;
    id_t                   tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  wr_en_q, wr_en_d;
    logic [REG_ID_BIT-1:0] wr_reg_q, wr_reg_d;
    id_t                   wr_rob_q, wr_rob_d;
    logic [31:0]           wr_val_q, wr_val_d;
    logic                  flush_q, flush_d;
    logic [31:0]           redirect_q, redirect_d;

    logic                  full;
    logic                  do_issue;
    logic                  do_commit;
    logic                  mispredict;

    assign full = (count_q == FULL_CNT);

    // Next-state: CDB capture, then issue, then commit; a mispredict overrides all.
    always_comb begin
        busy_d     = busy_q;
        ready_d    = ready_q;
        rd_d       = rd_q;
        is_br_d    = is_br_q;
        pred_d     = pred_q;
        pc_d       = pc_q;
        ent_val_d  = ent_val_q;
        taken_d    = taken_q;
        target_d   = target_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        wr_en_d    = 1'b0;
        wr_reg_d   = wr_reg_q;
        wr_rob_d   = wr_rob_q;
        wr_val_d   = wr_val_q;
        flush_d    = 1'b0;
        redirect_d = redirect_q;
        do_issue   = 1'b0;
        do_commit  = 1'b0;
        mispredict = 1'b0;

        if (rob_if.rdy_in) begin
            do_issue   = rob_if.issue_en && !full;
            do_commit  = (count_q != '0) && ready_q[head_q];
            mispredict = do_commit && is_br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);

            if (rob_if.cdb_en && busy_q[rob_if.cdb_rob_id]) begin
                ent_val_d[rob_if.cdb_rob_id] = rob_if.cdb_value;
                taken_d[rob_if.cdb_rob_id]   = rob_if.cdb_taken;
                target_d[rob_if.cdb_rob_id]  = rob_if.cdb_target;
                ready_d[rob_if.cdb_rob_id]   = 1'b1;
            end

            if (do_issue) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = 1'b0;
                rd_d[tail_q]    = rob_if.issue_rd;
                is_br_d[tail_q] = rob_if.issue_is_br;
                pred_d[tail_q]  = rob_if.issue_pred;
                pc_d[tail_q]    = rob_if.issue_pc;
                tail_d          = tail_q + id_t'(1);
            end

            if (do_commit) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + id_t'(1);
                wr_en_d         = (rd_q[head_q] != '0);
                wr_reg_d        = rd_q[head_q];
                wr_rob_d        = head_q;
                wr_val_d        = ent_val_q[head_q];
            end

            count_d = count_q + CW'(do_issue) - CW'(do_commit);

            if (mispredict) begin
                flush_d    = 1'b1;
                redirect_d = taken_q[head_q] ? target_q[head_q] : (pc_q[head_q] + 32'd4);
                for (int i = 0; i < DEPTH; i++) begin
                    busy_d[i]  = 1'b0;
                    ready_d[i] = 1'b0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
        end
    end

    // State registers; asynchronous clear of every entry and output.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]    <= 1'b0;
                ready_q[i]   <= 1'b0;
                rd_q[i]      <= '0;
                is_br_q[i]   <= 1'b0;
                pred_q[i]    <= 1'b0;
                pc_q[i]      <= '0;
                ent_val_q[i] <= '0;
                taken_q[i]   <= 1'b0;
                target_q[i]  <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_reg_q   <= '0;
            wr_rob_q   <= '0;
            wr_val_q   <= '0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            rd_q       <= rd_d;
            is_br_q    <= is_br_d;
            pred_q     <= pred_d;
            pc_q       <= pc_d;
            ent_val_q  <= ent_val_d;
            taken_q    <= taken_d;
            target_q   <= target_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            wr_en_q    <= wr_en_d;
            wr_reg_q   <= wr_reg_d;
            wr_rob_q   <= wr_rob_d;
            wr_val_q   <= wr_val_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
        end
    end

    // Operand lookups, with bypass from a CDB result arriving this cycle.
    always_comb begin
        rob_if.q1_ready = busy_q[rob_if.q1_id] &&
                          (ready_q[rob_if.q1_id] || (rob_if.cdb_en && rob_if.cdb_rob_id == rob_if.q1_id));
        rob_if.q1_value = '0;
        if (rob_if.q1_ready) begin
            rob_if.q1_value = (rob_if.cdb_en && rob_if.cdb_rob_id == rob_if.q1_id) ?
                              rob_if.cdb_value : ent_val_q[rob_if.q1_id];
        end
        rob_if.q2_ready = busy_q[rob_if.q2_id] &&
                          (ready_q[rob_if.q2_id] || (rob_if.cdb_en && rob_if.cdb_rob_id == rob_if.q2_id));
        rob_if.q2_value = '0;
        if (rob_if.q2_ready) begin
            rob_if.q2_value = (rob_if.cdb_en && rob_if.cdb_rob_id == rob_if.q2_id) ?
                              rob_if.cdb_value : ent_val_q[rob_if.q2_id];
        end
    end

    assign rob_if.tail_id     = tail_q;
    assign rob_if.rob_full    = full;
    assign rob_if.write_en    = wr_en_q;
    assign rob_if.reg_id      = wr_reg_q;
    assign rob_if.rob_id      = wr_rob_q;
    assign rob_if.value       = wr_val_q;
    assign rob_if.flush_out   = flush_q;
    assign rob_if.redirect_pc = redirect_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: commits are checked against a scoreboard
// filled at issue time; each scenario task also checks timing inline.
module tb_reorder_buffer;
    logic clk_in;
    logic rst_n_in;

    reorder_buffer_if #(.ROB_WIDTH_BIT(3), .REG_ID_BIT(5)) rob_if ();

    reorder_buffer #(.ROB_WIDTH_BIT(3), .REG_ID_BIT(5)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rob_if   (rob_if)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [2:0]  id;
        logic [31:0] val;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [2:0] mdl_tail;
    int         checks;
    int         errors;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Scoreboard: every commit pulse must match the oldest expected commit.
    always @(negedge clk_in) begin
        if (rst_n_in === 1'b1 && rob_if.write_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected: got rob_id=%0d reg_id=%0d, none expected",
                         rob_if.rob_id, rob_if.reg_id);
            end else begin
                mon_e = exp_q.pop_front();
                if (rob_if.reg_id !== mon_e.rd || rob_if.rob_id !== mon_e.id || rob_if.value !== mon_e.val) begin
                    errors++;
                    $display("FAIL commit_payload: got rd=%0d id=%0d val=%h, exp rd=%0d id=%0d val=%h",
                             rob_if.reg_id, rob_if.rob_id, rob_if.value, mon_e.rd, mon_e.id, mon_e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rob_if.rdy_in      = 1'b1;
        rob_if.issue_en    = 1'b0;
        rob_if.issue_rd    = '0;
        rob_if.issue_is_br = 1'b0;
        rob_if.issue_pred  = 1'b0;
        rob_if.issue_pc    = '0;
        rob_if.cdb_en      = 1'b0;
        rob_if.cdb_rob_id  = '0;
        rob_if.cdb_value   = '0;
        rob_if.cdb_taken   = 1'b0;
        rob_if.cdb_target  = '0;
        rob_if.q1_id       = '0;
        rob_if.q2_id       = '0;
    endtask

    task automatic apply_reset();
        rst_n_in = 1'b0;
        idle_inputs();
        exp_q.delete();
        mdl_tail = '0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic br, input logic pred,
                         input logic [31:0] pc, input logic [31:0] val);
        rob_if.issue_en    = 1'b1;
        rob_if.issue_rd    = rd;
        rob_if.issue_is_br = br;
        rob_if.issue_pred  = pred;
        rob_if.issue_pc    = pc;
        if (rd != 5'd0) exp_q.push_back('{rd, mdl_tail, val});
        mdl_tail = mdl_tail + 3'd1;
        step();
        rob_if.issue_en = 1'b0;
    endtask

    task automatic cdb(input logic [2:0] id, input logic [31:0] val,
                       input logic taken, input logic [31:0] target);
        rob_if.cdb_en     = 1'b1;
        rob_if.cdb_rob_id = id;
        rob_if.cdb_value  = val;
        rob_if.cdb_taken  = taken;
        rob_if.cdb_target = target;
        step();
        rob_if.cdb_en = 1'b0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected commits never seen, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        idle_inputs();
        #3;
        checks++;
        if (rob_if.tail_id !== 3'd0 || rob_if.rob_full !== 1'b0 || rob_if.write_en !== 1'b0 ||
            rob_if.flush_out !== 1'b0 || rob_if.redirect_pc !== 32'd0 || rob_if.value !== 32'd0 ||
            rob_if.reg_id !== 5'd0 || rob_if.rob_id !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: tail=%0d full=%0d we=%0d flush=%0d redir=%h val=%h, required all 0",
                     rob_if.tail_id, rob_if.rob_full, rob_if.write_en, rob_if.flush_out,
                     rob_if.redirect_pc, rob_if.value);
        end
        checks++;
        if (rob_if.q1_ready !== 1'b0 || rob_if.q1_value !== 32'd0) begin
            errors++;
            $display("FAIL reset_lookup: ready=%0d value=%h, required 0 0", rob_if.q1_ready, rob_if.q1_value);
        end
        apply_reset();
    endtask

    task automatic test_basic_commit();
        issue(5'd5, 1'b0, 1'b0, 32'h100, 32'h1234);
        checks++;
        if (rob_if.tail_id !== 3'd1) begin
            errors++;
            $display("FAIL basic_tail: got %0d required 1", rob_if.tail_id);
        end
        cdb(3'd0, 32'h1234, 1'b0, 32'h0);
        checks++;
        if (rob_if.write_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: write_en=%0d required 0", rob_if.write_en);
        end
        step();
        checks++;
        if (rob_if.write_en !== 1'b1 || rob_if.reg_id !== 5'd5 || rob_if.rob_id !== 3'd0 || rob_if.value !== 32'h1234) begin
            errors++;
            $display("FAIL basic_commit: we=%0d rd=%0d id=%0d val=%h required 1 5 0 1234",
                     rob_if.write_en, rob_if.reg_id, rob_if.rob_id, rob_if.value);
        end
        step();
        checks++;
        if (rob_if.write_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: write_en=%0d required 0", rob_if.write_en);
        end
        check_drained("basic_drain");
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 8; i++) issue(5'(i + 1), 1'b0, 1'b0, 32'h1000 + 32'(i * 4), 32'hA000 + 32'(i));
        checks++;
        if (rob_if.rob_full !== 1'b1 || rob_if.tail_id !== 3'd0) begin
            errors++;
            $display("FAIL full_after8: full=%0d tail=%0d required 1 0", rob_if.rob_full, rob_if.tail_id);
        end
        rob_if.issue_en = 1'b1;
        rob_if.issue_rd = 5'd9;
        step();
        rob_if.issue_en = 1'b0;
        checks++;
        if (rob_if.rob_full !== 1'b1 || rob_if.tail_id !== 3'd0) begin
            errors++;
            $display("FAIL full_ignore9: full=%0d tail=%0d required 1 0", rob_if.rob_full, rob_if.tail_id);
        end
        cdb(3'd0, 32'hA000, 1'b0, 32'h0);
        step();
        checks++;
        if (rob_if.rob_full !== 1'b0) begin
            errors++;
            $display("FAIL full_release: full=%0d required 0", rob_if.rob_full);
        end
        for (int i = 1; i < 8; i++) cdb(3'(i), 32'hA000 + 32'(i), 1'b0, 32'h0);
        repeat (3) step();
        check_drained("full_drain");
    endtask

    task automatic test_out_of_order();
        apply_reset();
        issue(5'd3, 1'b0, 1'b0, 32'h40, 32'hA);
        issue(5'd4, 1'b0, 1'b0, 32'h44, 32'hB);
        cdb(3'd1, 32'hB, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rob_if.write_en !== 1'b0) begin
                errors++;
                $display("FAIL ooo_wait: write_en=%0d required 0 at wait %0d", rob_if.write_en, i);
            end
        end
        cdb(3'd0, 32'hA, 1'b0, 32'h0);
        step();
        checks++;
        if (rob_if.write_en !== 1'b1 || rob_if.rob_id !== 3'd0) begin
            errors++;
            $display("FAIL ooo_first: we=%0d id=%0d required 1 0", rob_if.write_en, rob_if.rob_id);
        end
        step();
        checks++;
        if (rob_if.write_en !== 1'b1 || rob_if.rob_id !== 3'd1) begin
            errors++;
            $display("FAIL ooo_second: we=%0d id=%0d required 1 1", rob_if.write_en, rob_if.rob_id);
        end
        step();
        check_drained("ooo_drain");
    endtask

    task automatic test_flush();
        apply_reset();
        issue(5'd0, 1'b1, 1'b0, 32'h200, 32'h0);
        issue(5'd7, 1'b0, 1'b0, 32'h204, 32'h77);
        cdb(3'd1, 32'h77, 1'b0, 32'h0);
        cdb(3'd0, 32'h0, 1'b1, 32'h400);
        rob_if.issue_en = 1'b1;
        rob_if.issue_rd = 5'd9;
        step();
        rob_if.issue_en = 1'b0;
        checks++;
        if (rob_if.flush_out !== 1'b1 || rob_if.redirect_pc !== 32'h400 || rob_if.tail_id !== 3'd0 ||
            rob_if.rob_full !== 1'b0 || rob_if.write_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_taken: flush=%0d redir=%h tail=%0d we=%0d required 1 400 0 0",
                     rob_if.flush_out, rob_if.redirect_pc, rob_if.tail_id, rob_if.write_en);
        end
        // The younger rd=7 entry was discarded by the flush and never commits.
        checks++;
        if (exp_q.size() != 1) begin
            errors++;
            $display("FAIL flush_pending: queue size %0d required 1", exp_q.size());
        end
        exp_q.delete();
        mdl_tail = '0;
        rob_if.q1_id = 3'd1;
        #1;
        checks++;
        if (rob_if.q1_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_cleared: q1_ready=%0d required 0", rob_if.q1_ready);
        end
        step();
        checks++;
        if (rob_if.flush_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_pulse: flush=%0d required 0", rob_if.flush_out);
        end
        step();
        issue(5'd0, 1'b1, 1'b1, 32'h300, 32'h0);
        cdb(3'd0, 32'h0, 1'b0, 32'h999);
        step();
        checks++;
        if (rob_if.flush_out !== 1'b1 || rob_if.redirect_pc !== 32'h304) begin
            errors++;
            $display("FAIL flush_fallthru: flush=%0d redir=%h required 1 304", rob_if.flush_out, rob_if.redirect_pc);
        end
        mdl_tail = '0;
        step();
        issue(5'd0, 1'b1, 1'b1, 32'h500, 32'h0);
        issue(5'd2, 1'b0, 1'b0, 32'h504, 32'h22);
        cdb(3'd0, 32'h0, 1'b1, 32'h600);
        cdb(3'd1, 32'h22, 1'b0, 32'h0);
        checks++;
        if (rob_if.flush_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_correct_pred: flush=%0d required 0", rob_if.flush_out);
        end
        step();
        checks++;
        if (rob_if.write_en !== 1'b1 || rob_if.rob_id !== 3'd1) begin
            errors++;
            $display("FAIL flush_after_good_br: we=%0d id=%0d required 1 1", rob_if.write_en, rob_if.rob_id);
        end
        step();
        check_drained("flush_drain");
    endtask

    task automatic test_bypass();
        apply_reset();
        issue(5'd1, 1'b0, 1'b0, 32'h10, 32'h11);
        issue(5'd2, 1'b0, 1'b0, 32'h14, 32'h22);
        issue(5'd3, 1'b0, 1'b0, 32'h18, 32'h7);
        rob_if.q1_id      = 3'd2;
        rob_if.q2_id      = 3'd5;
        rob_if.cdb_en     = 1'b1;
        rob_if.cdb_rob_id = 3'd2;
        rob_if.cdb_value  = 32'd7;
        #1;
        checks++;
        if (rob_if.q1_ready !== 1'b1 || rob_if.q1_value !== 32'd7) begin
            errors++;
            $display("FAIL bypass_hit: ready=%0d value=%h required 1 7", rob_if.q1_ready, rob_if.q1_value);
        end
        checks++;
        if (rob_if.q2_ready !== 1'b0 || rob_if.q2_value !== 32'd0) begin
            errors++;
            $display("FAIL bypass_unbusy: ready=%0d value=%h required 0 0", rob_if.q2_ready, rob_if.q2_value);
        end
        rob_if.q2_id = 3'd1;
        #1;
        checks++;
        if (rob_if.q2_ready !== 1'b0 || rob_if.q2_value !== 32'd0) begin
            errors++;
            $display("FAIL bypass_pending: ready=%0d value=%h required 0 0", rob_if.q2_ready, rob_if.q2_value);
        end
        step();
        rob_if.cdb_en = 1'b0;
        #1;
        checks++;
        if (rob_if.q1_ready !== 1'b1 || rob_if.q1_value !== 32'd7) begin
            errors++;
            $display("FAIL bypass_stored: ready=%0d value=%h required 1 7", rob_if.q1_ready, rob_if.q1_value);
        end
        cdb(3'd0, 32'h11, 1'b0, 32'h0);
        cdb(3'd1, 32'h22, 1'b0, 32'h0);
        repeat (3) step();
        check_drained("bypass_drain");
    endtask

    task automatic test_rdy_pause();
        apply_reset();
        issue(5'd6, 1'b0, 1'b0, 32'h80, 32'h55);
        cdb(3'd0, 32'h55, 1'b0, 32'h0);
        rob_if.rdy_in   = 1'b0;
        rob_if.issue_en = 1'b1;
        rob_if.issue_rd = 5'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rob_if.write_en !== 1'b0 || rob_if.tail_id !== 3'd1) begin
                errors++;
                $display("FAIL pause_frozen: we=%0d tail=%0d required 0 1", rob_if.write_en, rob_if.tail_id);
            end
        end
        rob_if.issue_en = 1'b0;
        rob_if.rdy_in   = 1'b1;
        step();
        checks++;
        if (rob_if.write_en !== 1'b1 || rob_if.rob_id !== 3'd0) begin
            errors++;
            $display("FAIL pause_resume: we=%0d id=%0d required 1 0", rob_if.write_en, rob_if.rob_id);
        end
        step();
        checks++;
        if (rob_if.write_en !== 1'b0) begin
            errors++;
            $display("FAIL pause_once: we=%0d required 0", rob_if.write_en);
        end
        check_drained("pause_drain");
    endtask

    task automatic test_reset_mid();
        issue(5'd8, 1'b0, 1'b0, 32'h90, 32'h88);
        cdb(3'd1, 32'h88, 1'b0, 32'h0);
        step();
        checks++;
        if (rob_if.write_en !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: we=%0d required 1", rob_if.write_en);
        end
        @(negedge clk_in);
        #1;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (rob_if.write_en !== 1'b0 || rob_if.tail_id !== 3'd0 || rob_if.value !== 32'd0) begin
            errors++;
            $display("FAIL midreset_clear: we=%0d tail=%0d val=%h required 0 0 0",
                     rob_if.write_en, rob_if.tail_id, rob_if.value);
        end
        check_drained("midreset_drain");
        apply_reset();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        mdl_tail = '0;
        test_reset();
        test_basic_commit();
        test_full();
        test_out_of_order();
        test_flush();
        test_bypass();
        test_rdy_pause();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
